midi_in_port: RTL

//  Receive side of one MIDI input jack. Deserialises the 31250-baud MIDI line and frames

---
 rtl/midi_in_port.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/midi_in_port.sv
// MIDI input port: 2-flop synchroniser, UART receiver, running-status message framer,
// 3-byte message FIFO and Wishbone register slave. Optional define: MIDI_RT_PASS_EN.
module midi_in_port #(
    parameter int         BAUD_DIV        = 32,
    parameter int         FIFO_DEPTH_LOG2 = 2,
    parameter logic [3:0] PORT_ADDR       = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       midi_rx,
    input  logic [7:0] wb_addr,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    input  logic       wb_we_i,
    input  logic       wb_stb_i,
    output logic       wb_ack_o
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    typedef enum logic [1:0] {P_WAIT_STAT, P_WAIT_D0, P_WAIT_D1, P_SYSEX} p_state_t;

    // Status bytes that take two data bytes (channel voice except Cx/Dx, plus song position)
    function automatic logic need_two(input logic [7:0] s);
        logic r;
        case (s[7:4])
            4'hC, 4'hD: r = 1'b0;
            4'hF:       r = (s == 8'hF2);
            default:    r = 1'b1;
        endcase
        return r;
    endfunction

    logic            rx_meta_r, rx_sync_r;
    rx_state_t       rx_state_r, rx_next_s;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [2:0]      bit_cnt_r;
    logic [7:0]      shift_r;
    logic            rx_tick_s, sample_s, byte_ok_s, ferr_set_s;
    logic            byte_valid_r;

    p_state_t        p_state_r, p_next_s;
    logic [7:0]      rstat_r, stat_r, d0_r;
    logic            need2_r;
    logic            is_rt_s, is_stat_s;
    logic            push_s;
    logic [23:0]     push_msg_s;

    logic [23:0]     mem_r [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
    logic [FIFO_DEPTH_LOG2:0]   count_r;
    logic            full_s, empty_s, do_push_s, do_pop_s;
    logic [23:0]     head_s;

    logic            ovf_r, ferr_r;
    logic            sel_s, pop_req_s, clr_wr_s;
    logic [7:0]      rd_data_s;
    logic            unused_s;

    assign unused_s = ^{wb_dat_i[7:3], wb_dat_i[0]};

    // Two-flop synchroniser; idles high like the line
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= midi_rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receiver state register
    always_ff @(posedge clk) begin
        if (rst) rx_state_r <= RX_IDLE;
        else     rx_state_r <= rx_next_s;
    end

    // Receiver next-state logic
    always_comb begin
        rx_next_s = rx_state_r;
        case (rx_state_r)
            RX_IDLE:  if (!rx_sync_r) rx_next_s = RX_START; else rx_next_s = RX_IDLE;
            RX_START: if (rx_tick_s) rx_next_s = rx_sync_r ? RX_IDLE : RX_DATA;
                      else rx_next_s = RX_START;
            RX_DATA:  if (rx_tick_s && bit_cnt_r == 3'd7) rx_next_s = RX_STOP;
                      else rx_next_s = RX_DATA;
            RX_STOP:  if (rx_tick_s) rx_next_s = rx_sync_r ? RX_IDLE : RX_BREAK;
                      else rx_next_s = RX_STOP;
            RX_BREAK: if (rx_sync_r) rx_next_s = RX_IDLE; else rx_next_s = RX_BREAK;
            default:  rx_next_s = RX_IDLE;
        endcase
    end

    // Receiver outputs: bit-period tick and stop-bit verdicts
    always_comb begin
        rx_tick_s = 1'b0;
        case (rx_state_r)
            RX_START:        rx_tick_s = (baud_cnt_r == HALF_LAST);
            RX_DATA, RX_STOP: rx_tick_s = (baud_cnt_r == FULL_LAST);
            default:         rx_tick_s = 1'b0;
        endcase
        sample_s   = (rx_state_r == RX_DATA) && rx_tick_s;
        byte_ok_s  = (rx_state_r == RX_STOP) && rx_tick_s && rx_sync_r;
        ferr_set_s = (rx_state_r == RX_STOP) && rx_tick_s && !rx_sync_r;
    end

    // Receiver datapath: baud counter, bit counter, shifter, byte strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt_r   <= '0;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            byte_valid_r <= 1'b0;
        end else begin
            if (rx_state_r == RX_IDLE || rx_state_r == RX_BREAK || rx_tick_s)
                baud_cnt_r <= '0;
            else
                baud_cnt_r <= baud_cnt_r + 1'b1;
            if (rx_state_r != RX_DATA) bit_cnt_r <= 3'd0;
            else if (sample_s)         bit_cnt_r <= bit_cnt_r + 3'd1;
            if (sample_s) shift_r <= {rx_sync_r, shift_r[7:1]};
            byte_valid_r <= byte_ok_s;
        end
    end

    assign is_rt_s   = (shift_r >= 8'hF8);
    assign is_stat_s = shift_r[7];

    // Parser state register
    always_ff @(posedge clk) begin
        if (rst) p_state_r <= P_WAIT_STAT;
        else     p_state_r <= p_next_s;
    end

    // Parser next-state logic; realtime bytes never move the parser
    always_comb begin
        p_next_s = p_state_r;
        if (byte_valid_r && !is_rt_s) begin
            if (is_stat_s) begin
                if (shift_r[7:4] != 4'hF) p_next_s = P_WAIT_D0;
                else begin
                    case (shift_r[3:0])
                        4'h0:             p_next_s = P_SYSEX;
                        4'h1, 4'h2, 4'h3: p_next_s = P_WAIT_D0;
                        default:          p_next_s = P_WAIT_STAT;
                    endcase
                end
            end else begin
                case (p_state_r)
                    P_WAIT_STAT: p_next_s = (rstat_r != 8'h00 && need_two(rstat_r)) ?
                                            P_WAIT_D1 : P_WAIT_STAT;
                    P_WAIT_D0:   p_next_s = need2_r ? P_WAIT_D1 : P_WAIT_STAT;
                    P_WAIT_D1:   p_next_s = P_WAIT_STAT;
                    P_SYSEX:     p_next_s = P_SYSEX;
                    default:     p_next_s = P_WAIT_STAT;
                endcase
            end
        end else begin
            p_next_s = p_state_r;
        end
    end

    // Parser outputs: message completion pushes into the FIFO
    always_comb begin
        push_s     = 1'b0;
        push_msg_s = 24'h000000;
        if (byte_valid_r) begin
            if (is_rt_s) begin
`ifdef MIDI_RT_PASS_EN
                push_s     = 1'b1;
                push_msg_s = {shift_r, 16'h0000};
`else
                push_s     = 1'b0;
`endif
            end else if (is_stat_s) begin
                push_s     = (shift_r == 8'hF6);
                push_msg_s = {shift_r, 16'h0000};
            end else begin
                case (p_state_r)
                    P_WAIT_STAT: begin
                        push_s     = (rstat_r != 8'h00) && !need_two(rstat_r);
                        push_msg_s = {rstat_r, shift_r, 8'h00};
                    end
                    P_WAIT_D0: begin
                        push_s     = !need2_r;
                        push_msg_s = {stat_r, shift_r, 8'h00};
                    end
                    P_WAIT_D1: begin
                        push_s     = 1'b1;
                        push_msg_s = {stat_r, d0_r, shift_r};
                    end
                    default: push_s = 1'b0;
                endcase
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Parser datapath: running status, current status and first data byte
    always_ff @(posedge clk) begin
        if (rst) begin
            rstat_r <= 8'h00;
            stat_r  <= 8'h00;
            d0_r    <= 8'h00;
            need2_r <= 1'b0;
        end else if (byte_valid_r && !is_rt_s) begin
            if (is_stat_s) begin
                rstat_r <= (shift_r < 8'hF0) ? shift_r : 8'h00;
                stat_r  <= shift_r;
                need2_r <= need_two(shift_r);
            end else if (p_state_r == P_WAIT_STAT) begin
                stat_r  <= rstat_r;
                need2_r <= need_two(rstat_r);
                d0_r    <= shift_r;
            end else if (p_state_r == P_WAIT_D0) begin
                d0_r    <= shift_r;
            end
        end
    end

    assign full_s    = (count_r == (FIFO_DEPTH_LOG2+1)'(DEPTH));
    assign empty_s   = (count_r == '0);
    assign do_push_s = push_s && !full_s;
    assign do_pop_s  = pop_req_s && !empty_s;
    assign head_s    = empty_s ? 24'h000000 : mem_r[rd_ptr_r];

    // FIFO storage (no reset needed: reads are masked while empty)
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= push_msg_s;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            if (do_push_s && !do_pop_s)      count_r <= count_r + 1'b1;
            else if (do_pop_s && !do_push_s) count_r <= count_r - 1'b1;
        end
    end

    // Sticky error flags; a new event beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r  <= 1'b0;
            ferr_r <= 1'b0;
        end else begin
            if (push_s && full_s)                 ovf_r <= 1'b1;
            else if (clr_wr_s && wb_dat_i[1])     ovf_r <= 1'b0;
            if (ferr_set_s)                       ferr_r <= 1'b1;
            else if (clr_wr_s && wb_dat_i[2])     ferr_r <= 1'b0;
        end
    end

    assign sel_s     = wb_stb_i && (wb_addr[7:4] == PORT_ADDR) && !wb_ack_o;
    assign pop_req_s = sel_s && wb_we_i && (wb_addr[3:0] == 4'h4);
    assign clr_wr_s  = sel_s && wb_we_i && (wb_addr[3:0] == 4'h5);

    // Register read mux
    always_comb begin
        rd_data_s = 8'h00;
        case (wb_addr[3:0])
            4'h0:    rd_data_s = {4'(count_r), 1'b0, ferr_r, ovf_r, !empty_s};
            4'h1:    rd_data_s = head_s[23:16];
            4'h2:    rd_data_s = head_s[15:8];
            4'h3:    rd_data_s = head_s[7:0];
            default: rd_data_s = 8'h00;
        endcase
    end

    // Wishbone acknowledge and registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 8'h00;
        end else begin
            wb_ack_o <= sel_s;
            wb_dat_o <= (sel_s && !wb_we_i) ? rd_data_s : 8'h00;
        end
    end

endmodule
